// File: rtl/ppu_pkg.sv
// Shared definitions for the posit processing unit mantissa cores.
// Width derivation, the core state enum and the normalization rule used by multiplier and divider.
package ppu_pkg;

  function automatic int calc_mant_size(input int n);
    return n - 2;
  endfunction

  function automatic int calc_te_size(input int n, input int es);
    return es + $clog2(n) + 1;
  endfunction

  localparam int N         = 16;
  localparam int ES        = 1;
  localparam int MANT_SIZE = calc_mant_size(N);
  localparam int TE_SIZE   = calc_te_size(N, ES);
  localparam int PROD_W    = 2 * MANT_SIZE;
  localparam int CNT_W     = $clog2(MANT_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic [PROD_W-1:0]  mant;
    logic [TE_SIZE-1:0] te;
  } norm_res_t;

  // Product lies in [1,4): a set MSB means the value is >= 2, so bump the exponent instead of shifting.
  function automatic norm_res_t normalize(input logic [PROD_W-1:0] p,
                                          input logic [TE_SIZE-1:0] te1,
                                          input logic [TE_SIZE-1:0] te2);
    norm_res_t res;
    if (p[PROD_W-1]) begin
      res.mant = p;
      res.te   = te1 + te2 + TE_SIZE'(1);
    end else begin
      res.mant = {p[PROD_W-2:0], 1'b0};
      res.te   = te1 + te2;
    end
    return res;
  endfunction

endpackage

// File: rtl/core_mul_iter_if.sv
// Operand/result handshake bundle of the iterative mantissa multiplier.
// The slave modport is the core's view; the master modport is the producer/consumer side.
interface core_mul_iter_if;
  import ppu_pkg::*;

  logic                 valid_in;
  logic                 ready_in;
  logic [TE_SIZE-1:0]   te1;
  logic [TE_SIZE-1:0]   te2;
  logic [MANT_SIZE-1:0] mant1;
  logic [MANT_SIZE-1:0] mant2;
  logic                 valid_out;
  logic                 ready_out;
  logic [PROD_W-1:0]    mant_out;
  logic [TE_SIZE-1:0]   te_out;

  modport slave (
    input  valid_in, te1, te2, mant1, mant2, ready_out,
    output ready_in, valid_out, mant_out, te_out
  );

  modport master (
    output valid_in, te1, te2, mant1, mant2, ready_out,
    input  ready_in, valid_out, mant_out, te_out
  );

endinterface

// File: rtl/mant_norm.sv
// Combinational normalizer: turns a raw product in [1,4) and two operand exponents
// into the leading-one-at-MSB mantissa and matching total exponent.
module mant_norm
  import ppu_pkg::*;
(
  input  logic [PROD_W-1:0]  p_i,
  input  logic [TE_SIZE-1:0] te1_i,
  input  logic [TE_SIZE-1:0] te2_i,
  output logic [PROD_W-1:0]  mant_o,
  output logic [TE_SIZE-1:0] te_o
);

  norm_res_t res_d;

  // Apply the shared normalization rule
  always_comb begin
    res_d = normalize(p_i, te1_i, te2_i);
  end

  assign mant_o = res_d.mant;
  assign te_o   = res_d.te;

endmodule

// File: rtl/core_mul_iter.sv
// Iterative shift-and-add mantissa multiplier, one multiplier bit retired per cycle.
// Accumulator and multiplier share one product register that shifts right each iteration.
module core_mul_iter
  import ppu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  core_mul_iter_if.slave  bus
);

  mul_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [MANT_SIZE-1:0] mcand_q;
  logic [PROD_W-1:0]    prod_q;
  logic [TE_SIZE-1:0]   te1_q;
  logic [TE_SIZE-1:0]   te2_q;
  logic [PROD_W-1:0]    mant_out_q;
  logic [TE_SIZE-1:0]   te_out_q;

  logic [MANT_SIZE:0]   add_d;
  logic [PROD_W-1:0]    prod_d;
  logic [PROD_W-1:0]    norm_mant_d;
  logic [TE_SIZE-1:0]   norm_te_d;

  // One shift-and-add step; the carry out of the add becomes the new product MSB
  always_comb begin
    add_d  = {1'b0, prod_q[PROD_W-1:MANT_SIZE]};
    prod_d = prod_q;
    if (prod_q[0]) begin
      add_d = {1'b0, prod_q[PROD_W-1:MANT_SIZE]} + {1'b0, mcand_q};
    end else begin
      add_d = {1'b0, prod_q[PROD_W-1:MANT_SIZE]};
    end
    prod_d = {add_d, prod_q[MANT_SIZE-1:1]};
  end

  // Fed with the step result so the final iteration and the result register share one edge
  mant_norm u_mant_norm (
    .p_i    (prod_d),
    .te1_i  (te1_q),
    .te2_i  (te2_q),
    .mant_o (norm_mant_d),
    .te_o   (norm_te_d)
  );

  // Control FSM with datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      mcand_q    <= {MANT_SIZE{1'b0}};
      prod_q     <= {PROD_W{1'b0}};
      te1_q      <= {TE_SIZE{1'b0}};
      te2_q      <= {TE_SIZE{1'b0}};
      mant_out_q <= {PROD_W{1'b0}};
      te_out_q   <= {TE_SIZE{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            mcand_q <= bus.mant1;
            prod_q  <= {{MANT_SIZE{1'b0}}, bus.mant2};
            te1_q   <= bus.te1;
            te2_q   <= bus.te2;
            cnt_q   <= CNT_W'(MANT_SIZE);
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mant_out_q <= norm_mant_d;
            te_out_q   <= norm_te_d;
            state_q    <= DONE;
          end else begin
            state_q <= BUSY;
          end
        end
        DONE: begin
          if (bus.ready_out) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_in  = (state_q == IDLE);
  assign bus.valid_out = (state_q == DONE);
  assign bus.mant_out  = mant_out_q;
  assign bus.te_out    = te_out_q;

endmodule
